// File: rtl/cga_pkg.sv
// ============================================================================
// Package     : cga_pkg
// Description : Shared types, sequence constants and address helpers for the
//               CGA/Tandy VRAM fetch path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cga_pkg;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ_CHAR = 2'd1,
        ST_REQ_ATT  = 2'd2,
        ST_DONE     = 2'd3
    } fetch_state_t;

    // Character period in pixel clocks for high and low resolution
    localparam int unsigned SEQ_P_HRES = 16;
    localparam int unsigned SEQ_P_LRES = 32;

    // Slot offsets counted back from the end of the character period
    localparam int unsigned SEQ_OFS_DEADLINE = 4;
    localparam int unsigned SEQ_OFS_CHARROM  = 2;
    localparam int unsigned SEQ_OFS_DISP     = 1;

    // Sequence value of the slot lying 'ofs' clocks before the period end
    function automatic logic [4:0] seq_slot(input logic hres, input int unsigned ofs);
        int unsigned p;
        p = hres ? SEQ_P_HRES : SEQ_P_LRES;
        return 5'(p - ofs);
    endfunction

    // Even (character / first graphics) byte address; the odd byte is this | 1
    function automatic logic [13:0] fetch_base(input logic        grph,
                                               input logic [12:0] ma,
                                               input logic        bank);
        return grph ? {bank, ma[11:0], 1'b0} : {ma[12:0], 1'b0};
    endfunction

endpackage

`default_nettype wire

// File: rtl/cga_vram_fetch.sv
// ============================================================================
// Module      : cga_vram_fetch
// Description : Video-side VRAM fetch sequencer. Runs the per-character clock
//               sequence, fetches the character/attribute (or two graphics)
//               bytes from the arbiter and issues the delivery, character-ROM
//               and display-pipeline strobes for the pixel stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cga_vram_fetch
    import cga_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        hres_mode,
    input  logic        grph_mode,
    input  logic [13:0] crtc_ma,
    input  logic [4:0]  row_addr,
    input  logic        display_enable,
    input  logic        seq_sync,
    output logic        vram_req,
    output logic [13:0] vram_addr,
    input  logic        vram_ack,
    input  logic [7:0]  vram_rdata,
    output logic [4:0]  clk_seq,
    output logic        vram_read_char,
    output logic        vram_read_att,
    output logic [7:0]  vram_data,
    output logic        charrom_read,
    output logic        disp_pipeline,
    output logic        underrun,
    input  logic        underrun_clr
);

    fetch_state_t r_state, w_state_nxt;
    logic [4:0]   r_seq, w_seq_nxt;
    logic         r_hres, w_hres_nxt;
    logic         r_req, w_req_nxt;
    logic [13:0]  r_addr, w_addr_nxt;
    logic [7:0]   r_data, w_data_nxt;
    logic         r_rd_char, w_rd_char_nxt;
    logic         r_rd_att, w_rd_att_nxt;
    logic         r_crom, w_crom_nxt;
    logic         r_disp, w_disp_nxt;
    logic         r_underrun, w_underrun_nxt;
    logic         r_att_owed, w_att_owed_nxt;

    logic [4:0]   w_deadline;
    logic         w_wrap;
    logic         w_on_time;
    logic         w_late;
    logic         w_unused;

    // Address bits outside the fetch address range are not used
    assign w_unused   = ^{crtc_ma[13], row_addr[4:1]};

    assign w_deadline = seq_slot(r_hres, SEQ_OFS_DEADLINE);
    assign w_wrap     = (r_seq == seq_slot(r_hres, SEQ_OFS_DISP));
    // An ack in the deadline cycle itself still counts
    assign w_on_time  = (r_seq <= w_deadline);
    assign w_late     = (r_seq >= w_deadline);

    // Next-state and next-output logic for the sequencer and fetch FSM
    always_comb begin
        w_seq_nxt      = w_wrap ? 5'd0 : r_seq + 5'd1;
        w_hres_nxt     = w_wrap ? hres_mode : r_hres;
        w_state_nxt    = r_state;
        w_req_nxt      = r_req;
        w_addr_nxt     = r_addr;
        w_data_nxt     = r_data;
        w_rd_char_nxt  = 1'b0;
        w_rd_att_nxt   = 1'b0;
        w_att_owed_nxt = r_att_owed;
        w_underrun_nxt = r_underrun & ~underrun_clr;

        if (seq_sync) begin
            // Resynchronise: restart the character, withdraw any request and
            // discard an ack landing in this cycle
            w_seq_nxt      = 5'd0;
            w_state_nxt    = ST_IDLE;
            w_req_nxt      = 1'b0;
            w_att_owed_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if ((r_seq == 5'd0) && display_enable) begin
                        w_state_nxt = ST_REQ_CHAR;
                        w_req_nxt   = 1'b1;
                        w_addr_nxt  = fetch_base(grph_mode, crtc_ma[12:0], row_addr[0]);
                    end
                end
                ST_REQ_CHAR: begin
                    if (vram_ack && w_on_time) begin
                        w_data_nxt    = vram_rdata;
                        w_rd_char_nxt = 1'b1;
                        w_addr_nxt    = r_addr | 14'd1;
                        w_state_nxt   = ST_REQ_ATT;
                    end else if (w_late) begin
                        // Both bytes missed: blank char now, blank att next cycle
                        w_req_nxt      = 1'b0;
                        w_data_nxt     = 8'h00;
                        w_rd_char_nxt  = 1'b1;
                        w_att_owed_nxt = 1'b1;
                        w_underrun_nxt = 1'b1;
                        w_state_nxt    = ST_DONE;
                    end
                end
                ST_REQ_ATT: begin
                    if (vram_ack && w_on_time) begin
                        w_data_nxt   = vram_rdata;
                        w_rd_att_nxt = 1'b1;
                        w_req_nxt    = 1'b0;
                        w_state_nxt  = ST_DONE;
                    end else if (w_late) begin
                        w_req_nxt      = 1'b0;
                        w_data_nxt     = 8'h00;
                        w_rd_att_nxt   = 1'b1;
                        w_underrun_nxt = 1'b1;
                        w_state_nxt    = ST_DONE;
                    end
                end
                default: begin
                    if (r_att_owed) begin
                        w_data_nxt     = 8'h00;
                        w_rd_att_nxt   = 1'b1;
                        w_att_owed_nxt = 1'b0;
                    end
                    if (w_wrap) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            endcase
        end

        // Slot strobes are aligned with the sequence value they will appear with
        w_crom_nxt = (w_seq_nxt == seq_slot(r_hres, SEQ_OFS_CHARROM));
        w_disp_nxt = (w_seq_nxt == seq_slot(r_hres, SEQ_OFS_DISP));
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_seq      <= 5'd0;
            r_hres     <= 1'b0;
            r_req      <= 1'b0;
            r_addr     <= 14'd0;
            r_data     <= 8'h00;
            r_rd_char  <= 1'b0;
            r_rd_att   <= 1'b0;
            r_crom     <= 1'b0;
            r_disp     <= 1'b0;
            r_underrun <= 1'b0;
            r_att_owed <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_seq      <= w_seq_nxt;
            r_hres     <= w_hres_nxt;
            r_req      <= w_req_nxt;
            r_addr     <= w_addr_nxt;
            r_data     <= w_data_nxt;
            r_rd_char  <= w_rd_char_nxt;
            r_rd_att   <= w_rd_att_nxt;
            r_crom     <= w_crom_nxt;
            r_disp     <= w_disp_nxt;
            r_underrun <= w_underrun_nxt;
            r_att_owed <= w_att_owed_nxt;
        end
    end

    assign vram_req       = r_req;
    assign vram_addr      = r_addr;
    assign clk_seq        = r_seq;
    assign vram_read_char = r_rd_char;
    assign vram_read_att  = r_rd_att;
    assign vram_data      = r_data;
    assign charrom_read   = r_crom;
    assign disp_pipeline  = r_disp;
    assign underrun       = r_underrun;

endmodule

`default_nettype wire

// File: tb/tb_cga_vram_fetch.sv
// ============================================================================
// Module      : tb_cga_vram_fetch
// Description : Scoreboard bench for cga_vram_fetch with a latency-programmed
//               arbiter model and a character-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cga_vram_fetch;

    logic        clk;
    logic        reset;
    logic        hres_mode;
    logic        grph_mode;
    logic [13:0] crtc_ma;
    logic [4:0]  row_addr;
    logic        display_enable;
    logic        seq_sync;
    logic        vram_req;
    logic [13:0] vram_addr;
    logic        vram_ack;
    logic [7:0]  vram_rdata;
    logic [4:0]  clk_seq;
    logic        vram_read_char;
    logic        vram_read_att;
    logic [7:0]  vram_data;
    logic        charrom_read;
    logic        disp_pipeline;
    logic        underrun;
    logic        underrun_clr;

    cga_vram_fetch dut (
        .clk            (clk),
        .reset          (reset),
        .hres_mode      (hres_mode),
        .grph_mode      (grph_mode),
        .crtc_ma        (crtc_ma),
        .row_addr       (row_addr),
        .display_enable (display_enable),
        .seq_sync       (seq_sync),
        .vram_req       (vram_req),
        .vram_addr      (vram_addr),
        .vram_ack       (vram_ack),
        .vram_rdata     (vram_rdata),
        .clk_seq        (clk_seq),
        .vram_read_char (vram_read_char),
        .vram_read_att  (vram_read_att),
        .vram_data      (vram_data),
        .charrom_read   (charrom_read),
        .disp_pipeline  (disp_pipeline),
        .underrun       (underrun),
        .underrun_clr   (underrun_clr)
    );

    typedef struct {
        bit         att;
        int         seq;
        logic [7:0] data;
    } ev_t;

    ev_t         exp_q[$];
    logic [13:0] addr_q[$];

    int          n_checks = 0;
    int          n_errors = 0;
    bit          model_under = 0;
    bit          mon_en = 0;
    int          m_seq = 0;
    int          m_p = 32;
    int          cur_lc = 0;
    int          cur_la = 0;
    logic [7:0]  cur_dc = 8'h00;
    logic [7:0]  cur_da = 8'h00;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_ev(input bit att, input int seq, input logic [7:0] d);
        ev_t e;
        e.att  = att;
        e.seq  = seq;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Advance at least one cycle, then until clk_seq == v (bounded)
    task automatic wait_seq(input int v);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            seq_sync     = 1'b0;
            underrun_clr = 1'b0;
            n++;
        end while ((clk_seq != 5'(v)) && (n < 200));
        if (clk_seq != 5'(v)) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_seq: clk_seq=%0d never reached %0d", clk_seq, v);
        end
    endtask

    // Arbiter: acks a request after a programmed number of wait cycles
    initial begin : arbiter
        int          cnt;
        bit          prev_req;
        logic [13:0] prev_addr;
        cnt        = 0;
        prev_req   = 0;
        prev_addr  = '0;
        vram_ack   = 1'b0;
        vram_rdata = 8'h00;
        forever begin
            @(negedge clk);
            vram_ack = 1'b0;
            if (vram_req === 1'b1) begin
                if (!prev_req || (vram_addr != prev_addr)) cnt = 0;
                if (cnt == (vram_addr[0] ? cur_la : cur_lc)) begin
                    vram_ack   = 1'b1;
                    vram_rdata = vram_addr[0] ? cur_da : cur_dc;
                end else begin
                    vram_rdata = 8'($urandom);
                end
                cnt++;
            end
            prev_req  = (vram_req === 1'b1);
            prev_addr = vram_addr;
        end
    end

    // Monitor: sequence/slot model plus scoreboard pops on acks and strobes
    initial begin : monitor
        ev_t e;
        forever begin
            @(negedge clk);
            #1;
            if (mon_en) begin
                chk("clk_seq", 32'(clk_seq), 32'(m_seq));
                chk("charrom_read", 32'(charrom_read), 32'(m_seq == m_p - 2));
                chk("disp_pipeline", 32'(disp_pipeline), 32'(m_seq == m_p - 1));
                if (vram_req && vram_ack) begin
                    if (addr_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL vram_addr: unexpected ack at addr %04h", vram_addr);
                    end else begin
                        chk("vram_addr", 32'(vram_addr), 32'(addr_q.pop_front()));
                    end
                end
                if (vram_read_char || vram_read_att) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_errors++;
                        $display("FAIL strobe: unexpected char=%0b att=%0b at seq %0d data %02h",
                                 vram_read_char, vram_read_att, clk_seq, vram_data);
                    end else begin
                        e = exp_q.pop_front();
                        if ((vram_read_att !== e.att) || (vram_read_char !== !e.att) ||
                            (clk_seq !== 5'(e.seq)) || (vram_data !== e.data)) begin
                            n_errors++;
                            $display("FAIL strobe: got char=%0b att=%0b seq %0d data %02h, expected att=%0b seq %0d data %02h",
                                     vram_read_char, vram_read_att, clk_seq, vram_data, e.att, e.seq, e.data);
                        end
                    end
                end
                if (seq_sync || (m_seq == m_p - 1)) begin
                    if (m_seq == m_p - 1) m_p = hres_mode ? 16 : 32;
                    m_seq = 0;
                end else begin
                    m_seq++;
                end
            end
        end
    end

    // One character: called at the negedge of its clk_seq==0 cycle
    task automatic run_char(input bit de, input bit grph, input bit hres_nxt,
                            input logic [13:0] ma, input logic [4:0] row,
                            input int lc, input int la, input bit clr, input int sync_at);
        int         p, dl, s, base;
        logic [7:0] dc, da;
        chk("underrun", 32'(underrun), 32'(model_under));
        if (clr) begin
            underrun_clr = 1'b1;
            model_under  = 0;
        end
        p  = m_p;
        dl = p - 4;
        dc = 8'($urandom);
        da = 8'($urandom);
        display_enable = de;
        grph_mode      = grph;
        crtc_ma        = ma;
        row_addr       = row;
        hres_mode      = hres_nxt;
        cur_lc = lc;
        cur_la = la;
        cur_dc = dc;
        cur_da = da;
        if (de) begin
            base = grph ? (int'(row[0]) * 8192 + (int'(ma) % 4096) * 2) : (int'(ma) % 8192) * 2;
            if (1 + lc <= dl) begin
                addr_q.push_back(14'(base));
                push_ev(1'b0, lc + 2, dc);
                s = lc + 2;
                if (sync_at >= 0) begin
                    addr_q.push_back(14'(base + 1));
                end else if (s + la <= dl) begin
                    addr_q.push_back(14'(base + 1));
                    push_ev(1'b1, s + la + 1, da);
                end else begin
                    push_ev(1'b1, dl + 1, 8'h00);
                    model_under = 1;
                end
            end else begin
                push_ev(1'b0, dl + 1, 8'h00);
                push_ev(1'b1, dl + 2, 8'h00);
                model_under = 1;
            end
        end
        if (sync_at >= 0) begin
            wait_seq(sync_at);
            seq_sync = 1'b1;
            wait_seq(0);
            chk("vram_req_after_sync", 32'(vram_req), 32'd0);
        end else begin
            wait_seq(0);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_clk_seq"}, 32'(clk_seq), 32'd0);
        chk({tag, "_vram_req"}, 32'(vram_req), 32'd0);
        chk({tag, "_vram_addr"}, 32'(vram_addr), 32'd0);
        chk({tag, "_vram_data"}, 32'(vram_data), 32'd0);
        chk({tag, "_read_char"}, 32'(vram_read_char), 32'd0);
        chk({tag, "_read_att"}, 32'(vram_read_att), 32'd0);
        chk({tag, "_charrom"}, 32'(charrom_read), 32'd0);
        chk({tag, "_disp"}, 32'(disp_pipeline), 32'd0);
        chk({tag, "_underrun"}, 32'(underrun), 32'd0);
    endtask

    initial begin : driver
        reset          = 1'b1;
        hres_mode      = 1'b0;
        grph_mode      = 1'b0;
        crtc_ma        = '0;
        row_addr       = '0;
        display_enable = 1'b0;
        seq_sync       = 1'b0;
        underrun_clr   = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_values("reset");
        reset  = 1'b0;
        m_seq  = 0;
        m_p    = 32;
        mon_en = 1;
        wait_seq(0);

        // Graphics lowres, bank 1: 2020/2021; next character hres
        run_char(1, 1, 1, 14'h0010, 5'd1, 0, 0, 0, -1);
        // Text hres zero-wait: 0246/0247, strobes at 2 and 3
        run_char(1, 0, 1, 14'h0123, 5'd0, 0, 0, 0, -1);
        // Arbiter never answers: blank strobes at 13/14, underrun
        run_char(1, 0, 1, 14'h0200, 5'd0, 99, 0, 0, -1);
        // Attribute ack exactly at the deadline (seq 12)
        run_char(1, 0, 1, 14'h0300, 5'd0, 0, 10, 0, -1);
        // Underrun still sticky here, then cleared
        run_char(0, 0, 1, 14'h0000, 5'd0, 0, 0, 1, -1);
        run_char(1, 0, 1, 14'h1fff, 5'd3, 2, 1, 0, -1);
        // seq_sync while the attribute request is acked in the same cycle
        run_char(1, 1, 1, 14'h3abc, 5'd2, 0, 2, 0, 4);
        run_char(1, 0, 0, 14'h0044, 5'd0, 1, 1, 0, -1);

        for (int i = 0; i < 40; i++) begin
            int p, lc, la;
            p  = m_p;
            lc = ($urandom_range(0, 6) == 0) ? 99 : int'($urandom_range(0, p - 6));
            la = ($urandom_range(0, 6) == 0) ? 99 : int'($urandom_range(0, p));
            run_char(1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 14'($urandom), 5'($urandom),
                     lc, la, 1'($urandom_range(0, 3) == 0), -1);
        end

        // Leave underrun set, then reset in the middle of a fetch
        run_char(1, 0, 1, 14'h0abc, 5'd0, 99, 0, 0, -1);
        mon_en         = 0;
        display_enable = 1'b1;
        crtc_ma        = 14'h0155;
        hres_mode      = 1'b1;
        cur_lc         = 0;
        cur_la         = 99;
        cur_dc         = 8'h5a;
        wait_seq(4);
        chk("pre_reset_req", 32'(vram_req), 32'd1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_values("async_reset");
        exp_q.delete();
        addr_q.delete();
        model_under    = 0;
        display_enable = 1'b0;
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        m_seq  = 0;
        m_p    = 32;
        mon_en = 1;
        wait_seq(0);
        run_char(1, 0, 1, 14'h0042, 5'd0, 0, 0, 0, -1);
        run_char(1, 1, 0, 14'h0777, 5'd1, 1, 2, 0, -1);
        run_char(0, 0, 0, 14'h0000, 5'd0, 0, 0, 0, -1);

        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        chk("addr_q_drained", 32'(addr_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
